// File: rtl/stack_arbiter.sv
// -----------------------------------------------------------------------------
// stack_arbiter
//   Shares one external stack between NREQ requesters. A round-robin arbiter
//   picks one requester per transaction. The accepted op is driven onto the
//   stack strobes for one cycle, and the popped value is returned with a
//   one-cycle ack. A push on a full stack or a pop on an empty stack is answered
//   with err=1 and never reaches the stack.
//
//   Ports
//     clk, resetN         rising-edge clock, asynchronous active-low reset
//     req[NREQ]           per-requester request level
//     req_op[2*NREQ]      op of requester i at [2i+1:2i]: 00 none, 01 push,
//                         10 pop, 11 swap
//     req_data            push data of requester i at [WIDTH*i +: WIDTH]
//     ack[NREQ]           one-cycle completion pulse to the granted requester
//     err                 valid with ack; op rejected (full/empty)
//     rsp_data            valid with ack; popped value, otherwise 0
//     busy                high whenever the FSM is not in IDLE
//     stk_push/stk_pop    strobes to the stack, high only during ISSUE
//     stk_data_in         data to the stack, non-zero only during ISSUE
//     stk_data_out        data from the stack (valid after its falling edge)
//     stk_full/stk_empty  stack status, sampled only in IDLE
// -----------------------------------------------------------------------------
module stack_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]         ack,
  output logic                    err,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    busy,
  output logic                    stk_push,
  output logic                    stk_pop,
  output logic [WIDTH-1:0]        stk_data_in,
  input  logic [WIDTH-1:0]        stk_data_out,
  input  logic                    stk_full,
  input  logic                    stk_empty
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [GW-1:0] LAST_IDX = GW'(NREQ - 1);

  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Per-requester views of the packed request buses
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0] eligible;
  logic [1:0]      op_arr   [NREQ];
  logic [WIDTH-1:0] data_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign op_arr[gi]   = req_op[2*gi +: 2];
      assign data_arr[gi] = req_data[WIDTH*gi +: WIDTH];
      // A raised req with op "none" is not a transaction and is skipped.
      assign eligible[gi] = req[gi] && (req_op[2*gi +: 2] != 2'b00);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              was_empty_q, was_empty_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic              busy_q, busy_d;
  logic              stk_push_q, stk_push_d;
  logic              stk_pop_q, stk_pop_d;
  logic [WIDTH-1:0]  stk_data_in_q, stk_data_in_d;

  // ---------------------------------------------------------------------------
  // Round-robin pick: walk the indices starting just after the last grant,
  // wrapping at NREQ-1, and take the first eligible one.
  // ---------------------------------------------------------------------------
  logic          found;
  logic [GW-1:0] winner;
  logic [GW-1:0] cand;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = last_grant_q;
    for (int k = 0; k < NREQ; k++) begin
      if (cand == LAST_IDX) begin
        cand = '0;
      end else begin
        cand = cand + GW'(1);
      end
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  logic reject;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    op_d          = op_q;
    data_d        = data_q;
    was_empty_d   = was_empty_q;
    ack_d         = '0;
    err_d         = 1'b0;
    rsp_data_d    = '0;
    stk_push_d    = 1'b0;
    stk_pop_d     = 1'b0;
    stk_data_in_d = '0;
    reject        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d     = winner;
          op_d        = op_arr[winner];
          data_d      = data_arr[winner];
          // Remembered so a swap on an empty stack returns 0 rather than
          // whatever stale value the stack happens to present.
          was_empty_d = stk_empty;
          // Swap is never rejected: on a full stack it keeps depth, on an
          // empty stack it behaves as a push.
          reject = ((op_arr[winner] == OP_PUSH) && stk_full) ||
                   ((op_arr[winner] == OP_POP)  && stk_empty);
          if (reject) begin
            state_d        = RESP;
            ack_d[winner]  = 1'b1;
            err_d          = 1'b1;
          end else begin
            state_d       = ISSUE;
            stk_push_d    = op_arr[winner][0];
            stk_pop_d     = op_arr[winner][1];
            stk_data_in_d = data_arr[winner];
          end
        end
      end

      ISSUE: begin
        // The stack has acted on the falling edge inside this cycle, so
        // stk_data_out already holds the popped value here.
        state_d        = RESP;
        ack_d[grant_q] = 1'b1;
        if (op_q[1] && !(op_q[0] && was_empty_q)) begin
          rsp_data_d = stk_data_out;
        end
      end

      RESP: begin
        state_d      = IDLE;
        last_grant_d = grant_q;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      last_grant_q  <= LAST_IDX;
      grant_q       <= '0;
      op_q          <= 2'b00;
      data_q        <= '0;
      was_empty_q   <= 1'b0;
      ack_q         <= '0;
      err_q         <= 1'b0;
      rsp_data_q    <= '0;
      busy_q        <= 1'b0;
      stk_push_q    <= 1'b0;
      stk_pop_q     <= 1'b0;
      stk_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      op_q          <= op_d;
      data_q        <= data_d;
      was_empty_q   <= was_empty_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      rsp_data_q    <= rsp_data_d;
      busy_q        <= busy_d;
      stk_push_q    <= stk_push_d;
      stk_pop_q     <= stk_pop_d;
      stk_data_in_q <= stk_data_in_d;
    end
  end

  assign ack         = ack_q;
  assign err         = err_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = busy_q;
  assign stk_push    = stk_push_q;
  assign stk_pop     = stk_pop_q;
  assign stk_data_in = stk_data_in_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stack_arbiter
//   Bench for stack_arbiter with an 8-deep behavioural stack that acts on the
//   falling clock edge. Sequential single-requester transactions come from a
//   vector table; round-robin and reset-abort cases are hand-written. Expected
//   responses are queued when a request is raised and compared when ack fires.
// -----------------------------------------------------------------------------
module tb_stack_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 2;
  localparam int DEPTH = 8;

  localparam logic [1:0] PUSH = 2'b01;
  localparam logic [1:0] POP  = 2'b10;
  localparam logic [1:0] SWAP = 2'b11;

  logic                  clk;
  logic                  resetN;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic                  err;
  logic [WIDTH-1:0]      rsp_data;
  logic                  busy;
  logic                  stk_push;
  logic                  stk_pop;
  logic [WIDTH-1:0]      stk_data_in;
  logic [WIDTH-1:0]      stk_data_out;
  logic                  stk_full;
  logic                  stk_empty;

  stack_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .req          (req),
    .req_op       (req_op),
    .req_data     (req_data),
    .ack          (ack),
    .err          (err),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .stk_full     (stk_full),
    .stk_empty    (stk_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural stack: acts on the falling edge, data_out holds the last
  // popped value (0xEE until the first pop).
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];
  int               cnt;
  logic [WIDTH-1:0] stk_dout = 8'hEE;

  always @(negedge clk) begin
    if (!resetN) begin
      cnt <= 0;
    end else if (stk_push && stk_pop) begin
      if (cnt == 0) begin
        mem[0] <= stk_data_in;
        cnt    <= 1;
      end else begin
        stk_dout     <= mem[cnt-1];
        mem[cnt-1]   <= stk_data_in;
      end
    end else if (stk_push && cnt < DEPTH) begin
      mem[cnt] <= stk_data_in;
      cnt      <= cnt + 1;
    end else if (stk_pop && cnt > 0) begin
      stk_dout <= mem[cnt-1];
      cnt      <= cnt - 1;
    end
  end

  assign stk_data_out = stk_dout;
  assign stk_full     = (cnt == DEPTH);
  assign stk_empty    = (cnt == 0);

  // ---------------------------------------------------------------------------
  // Scoreboard and checking
  // ---------------------------------------------------------------------------
  typedef struct {
    int               who;
    logic             err;
    logic [WIDTH-1:0] rsp;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input int r, input logic [1:0] op, input logic [7:0] d,
                            input logic e_err, input logic [7:0] e_rsp);
    exp_t e;
    e.who  = r;
    e.err  = e_err;
    e.rsp  = e_rsp;
    e.push = !e_err && op[0];
    e.pop  = !e_err && op[1];
    e.din  = d;
    sb.push_back(e);
  endtask

  // Compares every ack against the head of the scoreboard, including the
  // stack strobes seen during the preceding ISSUE cycle.
  task automatic monitor();
    exp_t             e;
    logic             seen_push;
    logic             seen_pop;
    logic [WIDTH-1:0] seen_din;
    seen_push = 1'b0;
    seen_pop  = 1'b0;
    seen_din  = '0;
    forever begin
      @(negedge clk);
      if (!resetN) begin
        seen_push = 1'b0;
        seen_pop  = 1'b0;
        seen_din  = '0;
      end else if (ack != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          e = sb.pop_front();
          $display("txn: req%0d ack=%b err=%b rsp=%h push=%b pop=%b din=%h",
                   e.who, ack, err, rsp_data, seen_push, seen_pop, seen_din);
          check("ack_onehot", 32'(ack), 32'd1 << e.who);
          check("err", 32'(err), 32'(e.err));
          check("rsp_data", 32'(rsp_data), 32'(e.rsp));
          check("push_strobe", 32'(seen_push), 32'(e.push));
          check("pop_strobe", 32'(seen_pop), 32'(e.pop));
          if (e.push) check("stk_data_in", 32'(seen_din), 32'(e.din));
        end
        seen_push = 1'b0;
        seen_pop  = 1'b0;
      end else begin
        if (stk_push) begin
          seen_push = 1'b1;
          seen_din  = stk_data_in;
        end
        if (stk_pop) seen_pop = 1'b1;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Drivers. Both start and end on a falling edge with the DUT in IDLE.
  // ---------------------------------------------------------------------------
  task automatic run_txn(input int r, input logic [1:0] op, input logic [7:0] d,
                         input logic e_err, input logic [7:0] e_rsp);
    int   cyc;
    logic got;
    expect_txn(r, op, d, e_err, e_rsp);
    req[r]            = 1'b1;
    req_op[2*r +: 2]  = op;
    req_data[8*r +: 8] = d;
    cyc = 0;
    got = 1'b0;
    while (cyc < 8 && !got) begin
      @(negedge clk);
      cyc++;
      if (ack[r]) got = 1'b1;
    end
    check("ack_seen", 32'(got), 32'd1);
    if (got) begin
      check("latency", 32'(cyc), e_err ? 32'd1 : 32'd2);
      check("busy_resp", 32'(busy), 32'd1);
    end
    req[r]           = 1'b0;
    req_op[2*r +: 2] = 2'b00;
    @(negedge clk);
    check("outputs_after_resp", {21'd0, ack, err, rsp_data}, 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic requester(input int r, input int n, input logic [7:0] base);
    logic got;
    for (int k = 0; k < n; k++) begin
      req[r]             = 1'b1;
      req_op[2*r +: 2]   = PUSH;
      req_data[8*r +: 8] = base + 8'(k);
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (ack[r]) got = 1'b1;
      end
      check("pair_ack_seen", 32'(got), 32'd1);
      req[r]           = 1'b0;
      req_op[2*r +: 2] = 2'b00;
      @(negedge clk);
    end
  endtask

  // Both requesters push continuously; grants must alternate starting at 0.
  task automatic run_pair(input int n);
    for (int k = 0; k < n; k++) begin
      expect_txn(0, PUSH, 8'h40 + 8'(k), 1'b0, 8'h00);
      expect_txn(1, PUSH, 8'h50 + 8'(k), 1'b0, 8'h00);
    end
    fork
      requester(0, n, 8'h40);
      requester(1, n, 8'h50);
    join
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    req    = '0;
    req_op = '0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: single requester at a time, stack starts empty.
  // ---------------------------------------------------------------------------
  typedef struct {
    int         r;
    logic [1:0] op;
    logic [7:0] d;
    logic       e_err;
    logic [7:0] e_rsp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{0, PUSH, 8'hA5, 1'b0, 8'h00});
    vecs.push_back('{0, PUSH, 8'h01, 1'b0, 8'h00});
    vecs.push_back('{0, PUSH, 8'h02, 1'b0, 8'h00});
    vecs.push_back('{0, PUSH, 8'h03, 1'b0, 8'h00});
    vecs.push_back('{1, POP,  8'h00, 1'b0, 8'h03});
    vecs.push_back('{1, POP,  8'h00, 1'b0, 8'h02});
    vecs.push_back('{0, POP,  8'h00, 1'b0, 8'h01});
    vecs.push_back('{1, POP,  8'h00, 1'b0, 8'hA5});
    vecs.push_back('{1, POP,  8'h00, 1'b1, 8'h00});   // empty: rejected
    vecs.push_back('{0, PUSH, 8'h10, 1'b0, 8'h00});
    vecs.push_back('{1, PUSH, 8'h12, 1'b0, 8'h00});
    vecs.push_back('{0, PUSH, 8'h13, 1'b0, 8'h00});
    vecs.push_back('{1, PUSH, 8'h14, 1'b0, 8'h00});
    vecs.push_back('{0, PUSH, 8'h15, 1'b0, 8'h00});
    vecs.push_back('{1, PUSH, 8'h16, 1'b0, 8'h00});
    vecs.push_back('{0, PUSH, 8'h17, 1'b0, 8'h00});
    vecs.push_back('{1, PUSH, 8'h11, 1'b0, 8'h00});   // 8th: now full
    vecs.push_back('{0, PUSH, 8'h18, 1'b1, 8'h00});   // full: rejected
    vecs.push_back('{1, SWAP, 8'h22, 1'b0, 8'h11});   // swap on full is legal
    vecs.push_back('{0, POP,  8'h00, 1'b0, 8'h22});
    vecs.push_back('{1, POP,  8'h00, 1'b0, 8'h17});
    vecs.push_back('{0, POP,  8'h00, 1'b0, 8'h16});
    vecs.push_back('{1, POP,  8'h00, 1'b0, 8'h15});
    vecs.push_back('{0, POP,  8'h00, 1'b0, 8'h14});
    vecs.push_back('{1, POP,  8'h00, 1'b0, 8'h13});
    vecs.push_back('{0, POP,  8'h00, 1'b0, 8'h12});
    vecs.push_back('{1, POP,  8'h00, 1'b0, 8'h10});
    vecs.push_back('{0, SWAP, 8'h33, 1'b0, 8'h00});   // swap on empty
    vecs.push_back('{1, POP,  8'h00, 1'b0, 8'h33});
    vecs.push_back('{0, POP,  8'h00, 1'b1, 8'h00});

    resetN   = 1'b0;
    req      = '0;
    req_op   = '0;
    req_data = '0;

    fork
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rsp", 32'(rsp_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_push", 32'(stk_push), 32'd0);
    check("rst_pop", 32'(stk_pop), 32'd0);
    check("rst_din", 32'(stk_data_in), 32'd0);
    resetN = 1'b1;
    @(negedge clk);

    fork
      monitor();
    join_none

    foreach (vecs[i]) begin
      run_txn(vecs[i].r, vecs[i].op, vecs[i].d, vecs[i].e_err, vecs[i].e_rsp);
    end

    // Continuous contention after reset: requester 0 first, then alternate.
    do_reset();
    run_pair(3);

    // Reset asserted during ISSUE aborts with no ack.
    req[0]        = 1'b1;
    req_op[1:0]   = PUSH;
    req_data[7:0] = 8'h77;
    @(negedge clk);
    check("abort_issue_push", 32'(stk_push), 32'd1);
    check("abort_issue_din", 32'(stk_data_in), 32'h77);
    resetN = 1'b0;
    #1;
    check("abort_outputs",
          {19'd0, ack, err, rsp_data, busy, stk_push, stk_pop}, 32'd0);
    check("abort_din", 32'(stk_data_in), 32'd0);
    req    = '0;
    req_op = '0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    repeat (3) @(negedge clk);
    run_pair(1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
